// File: rtl/jtframe_padassign_pkg.sv
// Shared pad constants and helpers for the dynamic pad-to-slot assignment logic.
// Mirrors the pad layout used by the input conditioning stage.
package jtframe_padassign_pkg;
  localparam int NUM_PADS      = 4;
  localparam int PAD_W         = 16;
  localparam int START_BIT_DEF = 6;
  localparam int COIN_BIT_DEF  = 7;
  localparam logic [7:0] OWNER_RESET = 8'hE4;

  typedef logic [PAD_W-1:0] pad_word_t;
  typedef logic [1:0]       pad_idx_t;

  // Lowest-index slot whose valid bit is clear (0 when none is free).
  function automatic pad_idx_t first_free(input logic [NUM_PADS-1:0] valid);
    pad_idx_t idx;
    idx = '0;
    for (int i = NUM_PADS-1; i >= 0; i--) begin
      if (!valid[i]) idx = pad_idx_t'(i);
    end
    return idx;
  endfunction
endpackage

// File: rtl/jtframe_rr_arb.sv
// Four-way round-robin arbiter: picks the first requester at or above ptr, wrapping 3->0.
module jtframe_rr_arb
  import jtframe_padassign_pkg::*;
(
  input  logic [NUM_PADS-1:0] req,
  input  pad_idx_t            ptr,
  output logic [NUM_PADS-1:0] gnt,
  output pad_idx_t            gnt_idx,
  output logic                any
);
  always_comb begin
    pad_idx_t cand;
    cand    = '0;
    gnt_idx = '0;
    // Walk offsets from farthest to nearest so the nearest requester wins.
    for (int k = NUM_PADS-1; k >= 0; k--) begin
      cand = ptr + pad_idx_t'(k);
      if (req[cand]) gnt_idx = cand;
    end
    any = |req;
    gnt = any ? (NUM_PADS'(1) << gnt_idx) : '0;
  end
endmodule

// File: rtl/jtframe_padassign.sv
// Assigns physical pads to player slots on START, frees idle slots after a frame timeout,
// and routes each owner's pad word to its slot. enable=0 gives a registered identity map.
module jtframe_padassign
  import jtframe_padassign_pkg::*;
#(
  parameter int START_BIT      = START_BIT_DEF,
  parameter int TIMEOUT_FRAMES = 1800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vs,
  input  logic        enable,
  input  logic        lock,
  input  logic        clear,
  input  logic [15:0] pad_joy1,
  input  logic [15:0] pad_joy2,
  input  logic [15:0] pad_joy3,
  input  logic [15:0] pad_joy4,
  output logic [15:0] slot_joy1,
  output logic [15:0] slot_joy2,
  output logic [15:0] slot_joy3,
  output logic [15:0] slot_joy4,
  output logic [3:0]  slot_valid,
  output logic [7:0]  slot_owner,
  output logic        grant_evt
);
  localparam int CW = (TIMEOUT_FRAMES > 0) ? $clog2(TIMEOUT_FRAMES + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_FRAMES);

  pad_word_t pad_in [NUM_PADS];
  pad_word_t sync_q [NUM_PADS];
  pad_word_t sync_d [NUM_PADS];
  pad_word_t sjoy_q [NUM_PADS];
  pad_word_t sjoy_d [NUM_PADS];
  logic [CW-1:0] idle_q [NUM_PADS];
  logic [CW-1:0] idle_d [NUM_PADS];
  logic [NUM_PADS-1:0] prev_q, prev_d, valid_q, valid_d, asg_q, asg_d;
  logic [2*NUM_PADS-1:0] owner_q, owner_d;
  pad_idx_t rr_q, rr_d;
  logic vs_s_q, vs_s_d, vs_l_q, vs_l_d, en_q, en_d, gevt_q, gevt_d;
  logic [NUM_PADS-1:0] start_edge, req, gnt;
  pad_idx_t gnt_idx, free_idx;
  logic gnt_any, vs_rise;

  assign pad_in[0] = pad_joy1;
  assign pad_in[1] = pad_joy2;
  assign pad_in[2] = pad_joy3;
  assign pad_in[3] = pad_joy4;

  always_comb begin
    for (int p = 0; p < NUM_PADS; p++) begin
      sync_d[p]     = pad_in[p];
      prev_d[p]     = sync_q[p][START_BIT];
      start_edge[p] = sync_q[p][START_BIT] & ~prev_q[p];
    end
    req = start_edge & ~asg_q;
  end

  jtframe_rr_arb u_arb (
    .req     (req),
    .ptr     (rr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  always_comb begin
    pad_idx_t own;
    logic [CW-1:0] idle_inc;
    own      = '0;
    idle_inc = '0;
    vs_s_d   = vs;
    vs_l_d   = vs_s_q;
    en_d     = enable;
    vs_rise  = vs_s_q & ~vs_l_q;
    free_idx = first_free(valid_q);
    valid_d  = valid_q;
    asg_d    = asg_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    gevt_d   = 1'b0;
    for (int s = 0; s < NUM_PADS; s++) idle_d[s] = idle_q[s];

    if (!enable) begin
      valid_d = '0;
      asg_d   = '0;
      owner_d = OWNER_RESET;
      rr_d    = '0;
      for (int s = 0; s < NUM_PADS; s++) idle_d[s] = '0;
    end else if (clear) begin
      valid_d = '0;
      asg_d   = '0;
      for (int s = 0; s < NUM_PADS; s++) idle_d[s] = '0;
    end else if (!lock) begin
      for (int s = 0; s < NUM_PADS; s++) begin
        if (valid_q[s]) begin
          own      = owner_q[2*s +: 2];
          idle_inc = idle_q[s] + CW'(1);
          if (|sync_q[own]) begin
            idle_d[s] = '0;
          end else if (vs_rise && TIMEOUT_FRAMES != 0) begin
            idle_d[s] = idle_inc;
            if (idle_inc == TMAX) begin
              valid_d[s] = 1'b0;
              asg_d[own] = 1'b0;
              idle_d[s]  = '0;
            end
          end
        end
      end
      // Grant decision sees only slots free before this clk; slots freed above wait a cycle.
      if (gnt_any && !(&valid_q)) begin
        valid_d[free_idx]          = 1'b1;
        owner_d[2*free_idx +: 2]   = gnt_idx;
        asg_d                      = asg_d | gnt;
        idle_d[free_idx]           = '0;
        rr_d                       = gnt_idx + 2'd1;
        gevt_d                     = 1'b1;
      end
    end

    for (int p = 0; p < NUM_PADS; p++) begin
      sjoy_d[p] = '0;
      if (!lock) begin
        if (!enable) sjoy_d[p] = sync_q[p];
        else if (valid_q[p]) sjoy_d[p] = sync_q[owner_q[2*p +: 2]];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        sync_q[p] <= '0;
        sjoy_q[p] <= '0;
        idle_q[p] <= '0;
      end
      prev_q  <= '0;
      valid_q <= '0;
      asg_q   <= '0;
      owner_q <= OWNER_RESET;
      rr_q    <= '0;
      vs_s_q  <= 1'b0;
      vs_l_q  <= 1'b0;
      en_q    <= 1'b1;
      gevt_q  <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_PADS; p++) begin
        sync_q[p] <= sync_d[p];
        sjoy_q[p] <= sjoy_d[p];
        idle_q[p] <= idle_d[p];
      end
      prev_q  <= prev_d;
      valid_q <= valid_d;
      asg_q   <= asg_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      vs_s_q  <= vs_s_d;
      vs_l_q  <= vs_l_d;
      en_q    <= en_d;
      gevt_q  <= gevt_d;
    end
  end

  assign slot_joy1  = sjoy_q[0];
  assign slot_joy2  = sjoy_q[1];
  assign slot_joy3  = sjoy_q[2];
  assign slot_joy4  = sjoy_q[3];
  assign slot_valid = en_q ? valid_q : 4'hF;
  assign slot_owner = owner_q;
  assign grant_evt  = gevt_q;
endmodule

// File: tb/tb_jtframe_padassign.sv
// Scenario bench for jtframe_padassign with a slot-table reference model.
module tb_jtframe_padassign;
  logic clk = 1'b0;
  logic rst, vs, enable, lock, clear;
  logic [15:0] pj [4];
  logic [15:0] sj1, sj2, sj3, sj4;
  logic [3:0]  slot_valid;
  logic [7:0]  slot_owner;
  logic        grant_evt;
  int checks = 0;
  int failures = 0;

  // reference model: slot table, pad ownership flags, round-robin pointer
  bit m_valid [4];
  int m_owner [4];
  bit m_asg [4];
  int m_rr;

  jtframe_padassign #(.START_BIT(6), .TIMEOUT_FRAMES(4)) dut (
    .clk(clk), .rst(rst), .vs(vs), .enable(enable), .lock(lock), .clear(clear),
    .pad_joy1(pj[0]), .pad_joy2(pj[1]), .pad_joy3(pj[2]), .pad_joy4(pj[3]),
    .slot_joy1(sj1), .slot_joy2(sj2), .slot_joy3(sj3), .slot_joy4(sj4),
    .slot_valid(slot_valid), .slot_owner(slot_owner), .grant_evt(grant_evt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [15:0] sj(input int i);
    case (i)
      0: return sj1;
      1: return sj2;
      2: return sj3;
      default: return sj4;
    endcase
  endfunction

  function automatic logic [3:0] exp_valid();
    logic [3:0] v;
    for (int s = 0; s < 4; s++) v[s] = m_valid[s];
    return v;
  endfunction

  function automatic logic [7:0] exp_owner();
    logic [7:0] o;
    for (int s = 0; s < 4; s++) o[2*s +: 2] = 2'(m_owner[s]);
    return o;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      m_valid[s] = 1'b0;
      m_owner[s] = s;
      m_asg[s]   = 1'b0;
    end
    m_rr = 0;
  endtask

  task automatic model_clear();
    for (int s = 0; s < 4; s++) begin
      m_valid[s] = 1'b0;
      m_asg[s]   = 1'b0;
    end
  endtask

  // Winner = first unassigned requester from rr upward; it takes the lowest free slot.
  task automatic model_req(input logic [3:0] mask, output logic g);
    int w;
    int s;
    g = 1'b0;
    w = -1;
    s = -1;
    for (int k = 0; k < 4; k++) begin
      int p;
      p = (m_rr + k) % 4;
      if (w < 0 && mask[p] && !m_asg[p]) w = p;
    end
    for (int i = 3; i >= 0; i--) if (!m_valid[i]) s = i;
    if (w >= 0 && s >= 0) begin
      m_valid[s] = 1'b1;
      m_owner[s] = w;
      m_asg[w]   = 1'b1;
      m_rr       = (w + 1) % 4;
      g          = 1'b1;
    end
  endtask

  // START rises for the pads in mask; returns at n+2 (+1 time unit)
  task automatic press(input logic [3:0] mask);
    for (int p = 0; p < 4; p++) if (mask[p]) pj[p][6] = 1'b1;
    tick(1);
    for (int p = 0; p < 4; p++) if (mask[p]) pj[p][6] = 1'b0;
    tick(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    model_reset();
  endtask

  task automatic vs_pulse();
    vs = 1'b1;
    tick(2);
    vs = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    for (int p = 0; p < 4; p++) pj[p] = 16'($urandom) & 16'hFFBF;
    do_reset();
    tick(2);
    checks++; if (slot_valid !== 4'h0) begin failures++; $display("FAIL reset_valid got=%h want=0", slot_valid); end
    checks++; if (slot_owner !== 8'hE4) begin failures++; $display("FAIL reset_owner got=%h want=e4", slot_owner); end
    checks++; if (grant_evt !== 1'b0) begin failures++; $display("FAIL reset_grant got=%b want=0", grant_evt); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (sj(i) !== 16'h0) begin failures++; $display("FAIL reset_slot_joy%0d got=%h want=0", i+1, sj(i)); end
    end
    for (int p = 0; p < 4; p++) pj[p] = 16'h0;
    tick(2);
  endtask

  task automatic test_single_grant();
    logic g;
    do_reset();
    pj[2] = 16'h1234;
    tick(2);
    press(4'b0100);
    model_req(4'b0100, g);
    checks++; if (grant_evt !== 1'b1) begin failures++; $display("FAIL t1_grant got=%b want=1", grant_evt); end
    checks++; if (slot_valid !== 4'b0001) begin failures++; $display("FAIL t1_valid got=%b want=0001", slot_valid); end
    checks++; if (slot_owner[1:0] !== 2'd2) begin failures++; $display("FAIL t1_owner got=%0d want=2", slot_owner[1:0]); end
    checks++; if (sj1 !== 16'h0) begin failures++; $display("FAIL t1_joy_early got=%h want=0", sj1); end
    tick(1);
    checks++; if (sj1 !== 16'h1234) begin failures++; $display("FAIL t1_joy_n3 got=%h want=1234", sj1); end
    checks++; if (grant_evt !== 1'b0) begin failures++; $display("FAIL t1_pulse got=%b want=0", grant_evt); end
    pj[2] = 16'hA581;
    tick(2);
    checks++; if (sj1 !== 16'hA581) begin failures++; $display("FAIL t1_joy_follow got=%h want=a581", sj1); end
    pj[2] = 16'h0;
    tick(2);
  endtask

  task automatic test_arbitration();
    logic g;
    do_reset();
    press(4'b1001);
    model_req(4'b1001, g);
    checks++; if (grant_evt !== g) begin failures++; $display("FAIL t2_grant got=%b want=%b", grant_evt, g); end
    checks++; if (slot_valid !== exp_valid()) begin failures++; $display("FAIL t2_valid got=%b want=%b", slot_valid, exp_valid()); end
    checks++; if (slot_owner !== exp_owner()) begin failures++; $display("FAIL t2_owner got=%h want=%h", slot_owner, exp_owner()); end
    tick(3);
    checks++; if (slot_valid !== 4'b0001) begin failures++; $display("FAIL t2_dropped got=%b want=0001", slot_valid); end
    press(4'b1000);
    model_req(4'b1000, g);
    checks++; if (grant_evt !== 1'b1) begin failures++; $display("FAIL t2_regrant got=%b want=1", grant_evt); end
    checks++; if (slot_valid !== 4'b0011 || slot_owner[3:2] !== 2'd3) begin
      failures++; $display("FAIL t2_slot1 got valid=%b owner=%h want valid=0011 owner[3:2]=3", slot_valid, slot_owner);
    end
    tick(2);
  endtask

  task automatic test_timeout();
    logic g;
    do_reset();
    for (int p = 0; p < 4; p++) begin
      press(4'(1 << p));
      model_req(4'(1 << p), g);
      tick(2);
    end
    checks++; if (slot_valid !== 4'hF || slot_owner !== exp_owner()) begin
      failures++; $display("FAIL t3_full got valid=%h owner=%h want valid=f owner=%h", slot_valid, slot_owner, exp_owner());
    end
    pj[0] = 16'h0001; pj[2] = 16'h0100; pj[3] = 16'h8000; pj[1] = 16'h0;
    tick(2);
    for (int f = 0; f < 3; f++) vs_pulse();
    checks++; if (slot_valid !== 4'hF) begin failures++; $display("FAIL t3_before_timeout got=%h want=f", slot_valid); end
    vs_pulse();
    m_valid[1] = 1'b0;
    m_asg[1]   = 1'b0;
    checks++; if (slot_valid !== 4'b1101) begin failures++; $display("FAIL t3_timeout got=%b want=1101", slot_valid); end
    checks++; if (slot_owner !== exp_owner()) begin failures++; $display("FAIL t3_owner_kept got=%h want=%h", slot_owner, exp_owner()); end
    press(4'b0010);
    model_req(4'b0010, g);
    checks++; if (grant_evt !== 1'b1 || slot_valid !== 4'hF) begin
      failures++; $display("FAIL t3_reclaim got grant=%b valid=%h want grant=1 valid=f", grant_evt, slot_valid);
    end
    tick(2);
  endtask

  task automatic test_clear();
    logic g;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    model_clear();
    checks++; if (slot_valid !== 4'h0) begin failures++; $display("FAIL t4_clear got=%h want=0", slot_valid); end
    tick(2);
    pj[2][6] = 1'b1;
    tick(1);
    pj[2][6] = 1'b0;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    checks++; if (grant_evt !== 1'b0) begin failures++; $display("FAIL t4_clear_grant got=%b want=0", grant_evt); end
    checks++; if (slot_valid !== 4'h0) begin failures++; $display("FAIL t4_clear_valid got=%h want=0", slot_valid); end
    tick(2);
    press(4'b0100);
    model_req(4'b0100, g);
    checks++; if (grant_evt !== g || slot_valid !== exp_valid() || slot_owner !== exp_owner()) begin
      failures++; $display("FAIL t4_after_clear got grant=%b valid=%b owner=%h want grant=%b valid=%b owner=%h",
                           grant_evt, slot_valid, slot_owner, g, exp_valid(), exp_owner());
    end
    for (int p = 0; p < 4; p++) pj[p] = 16'h0;
    tick(2);
  endtask

  task automatic test_identity();
    logic g;
    enable = 1'b0;
    for (int it = 0; it < 4; it++) begin
      for (int p = 0; p < 4; p++) pj[p] = 16'($urandom);
      tick(2);
      for (int i = 0; i < 4; i++) begin
        checks++; if (sj(i) !== pj[i]) begin failures++; $display("FAIL t5_identity%0d got=%h want=%h", i+1, sj(i), pj[i]); end
      end
      checks++; if (slot_valid !== 4'hF || slot_owner !== 8'hE4 || grant_evt !== 1'b0) begin
        failures++; $display("FAIL t5_flags got valid=%h owner=%h grant=%b want f e4 0", slot_valid, slot_owner, grant_evt);
      end
    end
    enable = 1'b1;
    tick(1);
    model_reset();
    checks++; if (slot_valid !== 4'h0) begin failures++; $display("FAIL t5_reenable got=%h want=0", slot_valid); end
    for (int p = 0; p < 4; p++) pj[p] = 16'h0;
    tick(2);
    press(4'b0010);
    model_req(4'b0010, g);
    checks++; if (slot_valid !== exp_valid() || slot_owner !== exp_owner()) begin
      failures++; $display("FAIL t5_fresh got valid=%b owner=%h want valid=%b owner=%h", slot_valid, slot_owner, exp_valid(), exp_owner());
    end
    tick(2);
  endtask

  task automatic test_lock_and_rst();
    logic g;
    do_reset();
    press(4'b1000); model_req(4'b1000, g); tick(2);
    press(4'b0010); model_req(4'b0010, g); tick(2);
    pj[3] = (16'($urandom) & 16'hFFBF) | 16'h0001;
    pj[1] = (16'($urandom) & 16'hFFBF) | 16'h0002;
    tick(2);
    lock = 1'b1;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      checks++; if (sj(i) !== 16'h0) begin failures++; $display("FAIL t6_lock_joy%0d got=%h want=0", i+1, sj(i)); end
    end
    checks++; if (slot_valid !== exp_valid() || slot_owner !== exp_owner()) begin
      failures++; $display("FAIL t6_lock_table got valid=%b owner=%h want valid=%b owner=%h", slot_valid, slot_owner, exp_valid(), exp_owner());
    end
    press(4'b0001);
    checks++; if (grant_evt !== 1'b0 || slot_valid !== 4'b0011) begin
      failures++; $display("FAIL t6_lock_start got grant=%b valid=%b want grant=0 valid=0011", grant_evt, slot_valid);
    end
    pj[1] = 16'h0; pj[3] = 16'h0;
    tick(2);
    for (int f = 0; f < 6; f++) vs_pulse();
    pj[3] = 16'h5A00;
    pj[1] = 16'h0033;
    tick(2);
    lock = 1'b0;
    tick(2);
    checks++; if (slot_valid !== 4'b0011) begin failures++; $display("FAIL t6_frozen got=%b want=0011", slot_valid); end
    checks++; if (sj1 !== 16'h5A00) begin failures++; $display("FAIL t6_resume1 got=%h want=5a00", sj1); end
    checks++; if (sj2 !== 16'h0033) begin failures++; $display("FAIL t6_resume2 got=%h want=0033", sj2); end
    pj[0][6] = 1'b1;
    tick(1);
    #2 rst = 1'b1;
    #1;
    checks++; if (slot_valid !== 4'h0 || slot_owner !== 8'hE4 || grant_evt !== 1'b0) begin
      failures++; $display("FAIL t6_async_rst got valid=%h owner=%h grant=%b want 0 e4 0", slot_valid, slot_owner, grant_evt);
    end
    checks++; if (sj1 !== 16'h0 || sj2 !== 16'h0) begin failures++; $display("FAIL t6_rst_joy got=%h %h want=0 0", sj1, sj2); end
    for (int p = 0; p < 4; p++) pj[p] = 16'h0;
    tick(1);
    rst = 1'b0;
    model_reset();
    tick(2);
    checks++; if (grant_evt !== 1'b0 || slot_valid !== 4'h0) begin
      failures++; $display("FAIL t6_post_rst got grant=%b valid=%h want 0 0", grant_evt, slot_valid);
    end
  endtask

  task automatic test_random();
    logic g;
    logic [3:0] mask;
    logic [15:0] want;
    do_reset();
    for (int it = 0; it < 24; it++) begin
      if (m_valid[0] && m_valid[1] && m_valid[2] && m_valid[3]) begin
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        model_clear();
        checks++; if (slot_valid !== 4'h0) begin failures++; $display("FAIL rnd_clear got=%h want=0", slot_valid); end
      end
      mask = 4'($urandom_range(1, 15));
      press(mask);
      model_req(mask, g);
      checks++; if (grant_evt !== g) begin failures++; $display("FAIL rnd_grant it=%0d mask=%b got=%b want=%b", it, mask, grant_evt, g); end
      checks++; if (slot_valid !== exp_valid() || slot_owner !== exp_owner()) begin
        failures++; $display("FAIL rnd_table it=%0d got valid=%b owner=%h want valid=%b owner=%h",
                             it, slot_valid, slot_owner, exp_valid(), exp_owner());
      end
      for (int p = 0; p < 4; p++) pj[p] = 16'($urandom) & 16'hFFBF;
      tick(2);
      for (int s = 0; s < 4; s++) begin
        want = m_valid[s] ? pj[m_owner[s]] : 16'h0;
        checks++; if (sj(s) !== want) begin failures++; $display("FAIL rnd_route it=%0d slot=%0d got=%h want=%h", it, s, sj(s), want); end
      end
      for (int p = 0; p < 4; p++) pj[p] = 16'h0;
      tick(2);
    end
  endtask

  initial begin
    rst = 1'b1; vs = 1'b0; enable = 1'b1; lock = 1'b0; clear = 1'b0;
    for (int p = 0; p < 4; p++) pj[p] = 16'h0;
    model_reset();
    test_reset();
    test_single_grant();
    test_arbitration();
    test_timeout();
    test_clear();
    test_identity();
    test_lock_and_rst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
